// File: rtl/core_pkg.sv
// Shared core datapath types: ALU select encoding width and the request
// bundle handed from issue to the ALU (also used by the execute stage).
package core_pkg;

    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned XLEN     = 32;

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    // One ALU request: two operands plus the unmodified op-select.
    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        alu_op_t         op;
    } alu_req_t;

endpackage : core_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans req from index ptr upward,
// wrapping modulo N. The first set bit wins. Pointer state lives in the
// instantiating block. grant_idx is 0 when nothing requests.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Priority scan from ptr; the winner is reported even when enable is low
    // so the ALU inputs can be steered before the transfer is allowed.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        grant     = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((32'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (found && enable) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule : rr_arbiter

// File: rtl/alu_arbiter.sv
// Shares one combinational integer ALU between N_REQ requesters.
// Round-robin picks a winner, its operands drive the ALU, and the ALU result
// is captured into a one-entry valid/ready response register.
module alu_arbiter
    import core_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_REQ = 2,
    parameter int ID_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*WIDTH-1:0]    req_a,
    input  logic [N_REQ*WIDTH-1:0]    req_b,
    input  logic [N_REQ*ALU_OP_W-1:0] req_op,
    output logic [WIDTH-1:0]          alu_i0,
    output logic [WIDTH-1:0]          alu_i1,
    output logic [ALU_OP_W-1:0]       alu_s,
    input  logic [WIDTH-1:0]          alu_o,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WIDTH-1:0]          rsp_data,
    output logic [ID_W-1:0]           rsp_id
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] g_idx;
    logic [N_REQ-1:0] grant;
    logic             can_accept;
    logic             accept;

    // Response slot is free, or is being drained this same cycle.
    assign can_accept = !rsp_valid || rsp_ready;

    // Reset blocks acceptance so a request offered during reset is not taken.
    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .enable    (can_accept && !rst),
        .grant     (grant),
        .grant_idx (g_idx)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    // With no winner g_idx is 0, so the ALU sees requester 0's fields: stable,
    // never X.
    assign alu_i0 = req_a[g_idx*WIDTH +: WIDTH];
    assign alu_i1 = req_b[g_idx*WIDTH +: WIDTH];
    assign alu_s  = req_op[g_idx*ALU_OP_W +: ALU_OP_W];

    // Response register and round-robin pointer; ptr moves only on an accept.
    always_ff @(posedge clk) begin
        // NOTE: synchronous reset, sampled only on the rising edge. State
        // updates use non-blocking assignments so every register sees
        // pre-edge values.
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            ptr       <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_o;
            rsp_id    <= ID_W'(g_idx);
            ptr       <= (g_idx == IDX_W'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a vector table for the 2-requester
// instance plus hand-written reset and 3-requester sequences. A small ALU
// model closes the combinational alu_o loop.
module tb_alu_arbiter;
    import core_pkg::*;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] alu_f(input logic [31:0] x, input logic [31:0] y,
                                          input logic [3:0] s);
        case (s)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_XOR:  return x ^ y;
            OP_OR:   return x | y;
            default: return '0;
        endcase
    endfunction

    // ---------------- 2-requester instance ----------------
    logic [1:0]  req_valid, req_ready;
    alu_req_t    r0, r1;
    logic [31:0] alu_i0, alu_i1, alu_o, rsp_data;
    logic [3:0]  alu_s;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_id;

    assign alu_o = alu_f(alu_i0, alu_i1, alu_s);

    alu_arbiter #(.WIDTH(32), .N_REQ(2), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     ({r1.a, r0.a}),
        .req_b     ({r1.b, r0.b}),
        .req_op    ({r1.op, r0.op}),
        .alu_i0    (alu_i0),
        .alu_i1    (alu_i1),
        .alu_s     (alu_s),
        .alu_o     (alu_o),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    // ---------------- 3-requester instance ----------------
    logic [2:0]  v3, rdy3;
    logic [95:0] a3, b3;
    logic [11:0] op3;
    logic [31:0] i0_3, i1_3, o_3, data3;
    logic [3:0]  s_3;
    logic        rv3, rr3;
    logic [1:0]  id3;

    assign o_3 = alu_f(i0_3, i1_3, s_3);

    alu_arbiter #(.WIDTH(32), .N_REQ(3), .ID_W(2)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (v3),
        .req_ready (rdy3),
        .req_a     (a3),
        .req_b     (b3),
        .req_op    (op3),
        .alu_i0    (i0_3),
        .alu_i1    (i1_3),
        .alu_s     (s_3),
        .alu_o     (o_3),
        .rsp_valid (rv3),
        .rsp_ready (rr3),
        .rsp_data  (data3),
        .rsp_id    (id3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  v;
        alu_req_t    q0;
        alu_req_t    q1;
        logic        rdy;
        logic [1:0]  exp_ready;
        logic [31:0] exp_i0;
        logic        exp_rv;
        logic [31:0] exp_data;
        logic [1:0]  exp_id;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] v, input alu_req_t q0, input alu_req_t q1,
                                input logic rdy, input logic [1:0] er, input logic [31:0] ei0,
                                input logic erv, input logic [31:0] ed, input logic [1:0] eid);
        vec_t t;
        t.v = v; t.q0 = q0; t.q1 = q1; t.rdy = rdy;
        t.exp_ready = er; t.exp_i0 = ei0;
        t.exp_rv = erv; t.exp_data = ed; t.exp_id = eid;
        return t;
    endfunction

    // Inputs are driven 1 time unit after a rising edge; combinational outputs
    // are checked 1 unit later, registered outputs 1 unit after the next edge.
    task automatic apply(input vec_t t, input int idx);
        req_valid = t.v; r0 = t.q0; r1 = t.q1; rsp_ready = t.rdy;
        #1;
        check($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'(t.exp_ready));
        check($sformatf("v%0d alu_i0", idx), alu_i0, t.exp_i0);
        @(posedge clk); #1;
        check($sformatf("v%0d rsp_valid", idx), 32'(rsp_valid), 32'(t.exp_rv));
        check($sformatf("v%0d rsp_data", idx), rsp_data, t.exp_data);
        check($sformatf("v%0d rsp_id", idx), 32'(rsp_id), 32'(t.exp_id));
    endtask

    initial begin
        alu_req_t z, p_or, p_sub, p_a, p_b, p_one, p_x, p_aa, p_bb;
        z     = '{a: 32'h0,     b: 32'h0,      op: OP_ADD};
        p_or  = '{a: 32'hF0,    b: 32'hF0F,    op: OP_OR};   // -> 0xFFF
        p_sub = '{a: 32'h5,     b: 32'h3,      op: OP_SUB};  // -> 0x2
        p_a   = '{a: 32'h10,    b: 32'h1,      op: OP_ADD};  // -> 0x11
        p_b   = '{a: 32'h20,    b: 32'h3,      op: OP_SUB};  // -> 0x1D
        p_one = '{a: 32'h0,     b: 32'h1,      op: OP_ADD};  // -> 0x1
        p_x   = '{a: 32'h100,   b: 32'h0F0,    op: OP_XOR};  // -> 0x1F0
        p_aa  = '{a: 32'hAA,    b: 32'h0,      op: OP_ADD};
        p_bb  = '{a: 32'hBB,    b: 32'h0,      op: OP_ADD};

        // Post-reset state: ptr=0, rsp_valid=0.
        vecs.push_back(mk(2'b01, p_or, z,     1'b1, 2'b01, 32'hF0,  1'b1, 32'hFFF, 2'd0)); // single op
        vecs.push_back(mk(2'b10, z,    p_sub, 1'b1, 2'b10, 32'h5,   1'b1, 32'h2,   2'd1)); // drain+accept, ptr->0
        vecs.push_back(mk(2'b00, p_aa, z,     1'b1, 2'b00, 32'hAA,  1'b0, 32'h2,   2'd1)); // drain, no winner
        for (int i = 0; i < 6; i++) begin                                                  // round robin
            if (i % 2 == 0)
                vecs.push_back(mk(2'b11, p_a, p_b, 1'b1, 2'b01, 32'h10, 1'b1, 32'h11, 2'd0));
            else
                vecs.push_back(mk(2'b11, p_a, p_b, 1'b1, 2'b10, 32'h20, 1'b1, 32'h1D, 2'd1));
        end
        vecs.push_back(mk(2'b01, p_one, z, 1'b1, 2'b01, 32'h0, 1'b1, 32'h1, 2'd0));        // result 1, ptr->1
        for (int i = 0; i < 3; i++)                                                         // backpressure
            vecs.push_back(mk(2'b10, z, p_x, 1'b0, 2'b00, 32'h100, 1'b1, 32'h1, 2'd0));
        vecs.push_back(mk(2'b10, z,    p_x, 1'b1, 2'b10, 32'h100, 1'b1, 32'h1F0, 2'd1));   // release
        vecs.push_back(mk(2'b00, p_bb, z,   1'b1, 2'b00, 32'hBB,  1'b0, 32'h1F0, 2'd1));   // drain, ptr=0

        // Idle the 3-requester instance until its own sequence.
        v3 = '0; a3 = '0; b3 = '0; op3 = '0; rr3 = 1'b1;

        // ---- Reset held 2 cycles with both requesters valid ----
        rst = 1'b1; req_valid = 2'b11; r0 = p_a; r1 = p_b; rsp_ready = 1'b1;
        #1;
        check("reset req_ready pre-edge", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        check("reset req_ready cycle1", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        check("reset req_ready cycle2", 32'(req_ready), 32'h0);
        check("reset rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset rsp_data", rsp_data, 32'h0);
        check("reset rsp_id", 32'(rsp_id), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // ---- Reset in the same cycle as an accept, with rsp_valid=1 ----
        req_valid = 2'b01; r0 = p_a; rsp_ready = 1'b1;
        @(posedge clk); #1;                       // accept req0, ptr -> 1
        check("mid-reset setup rsp_valid", 32'(rsp_valid), 32'h1);
        req_valid = 2'b11; r0 = p_a; r1 = p_b; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid-reset rsp_valid", 32'(rsp_valid), 32'h0);
        check("mid-reset rsp_data", rsp_data, 32'h0);
        #1;
        check("post-reset grant to req0", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        check("post-reset rsp_id", 32'(rsp_id), 32'h0);
        check("post-reset rsp_data", rsp_data, 32'h11);
        req_valid = 2'b00;

        // ---- N_REQ=3: only req2, then all three ----
        a3 = {32'h3, 32'h2, 32'h1};               // req i yields i+1 with ADD
        b3 = '0; op3 = {OP_ADD, OP_ADD, OP_ADD};
        v3 = 3'b100;
        #1;
        check("n3 req2 ready", 32'(rdy3), 32'h4);
        @(posedge clk); #1;
        check("n3 req2 rsp_id", 32'(id3), 32'h2);
        check("n3 req2 rsp_data", data3, 32'h3);
        v3 = 3'b111;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("n3 rr%0d ready", k), 32'(rdy3), 32'(1 << k));
            @(posedge clk); #1;
            check($sformatf("n3 rr%0d rsp_valid", k), 32'(rv3), 32'h1);
            check($sformatf("n3 rr%0d rsp_id", k), 32'(id3), 32'(k));
            check($sformatf("n3 rr%0d rsp_data", k), data3, 32'(k + 1));
        end
        v3 = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_alu_arbiter

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single integer ALU between N_REQ requesters, e.g. the execute stage and the address-generation/branch-compare path.
- Each cycle the block round-robin arbitrates valid requests and drives the winner's operands and op-select onto the ALU input bus.
- It captures the ALU's combinational output into a one-entry response register with valid/ready backpressure.
- It sits between the issue logic and the ALU instance in the core datapath.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU WIDTH.
- N_REQ, 2, number of requesters; legal range 2..4.
- ID_W, 2, width of the response requester-id field; must satisfy 2**ID_W >= N_REQ.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept; one-hot or zero.
- req_a  input  N_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- req_b  input  N_REQ*WIDTH  operand B, same packing as req_a.
- req_op  input  N_REQ*4  ALU select, requester i at bits [i*4 +: 4].
- alu_i0  output  WIDTH  to ALU operand 0.
- alu_i1  output  WIDTH  to ALU operand 1.
- alu_s  output  4  to ALU select.
- alu_o  input  WIDTH  ALU result; combinational same-cycle path from alu_i0/alu_i1/alu_s.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accept.
- rsp_data  output  WIDTH  registered ALU result.
- rsp_id  output  ID_W  index of the requester that owns rsp_data.

Behaviour:
- Reset (rst=1 at posedge): rsp_valid=0, rsp_data=0, rsp_id=0, priority pointer ptr=0. rst overrides any same-cycle accept or drain. A request offered in the reset cycle is not accepted.
- can_accept = !rsp_valid | rsp_ready. The response register is free or being drained this cycle.
- Grant (combinational):
  - Scan req_valid starting at index ptr, wrapping modulo N_REQ.
  - The first set bit is the winner g. If no bit is set, there is no winner.
  - req_ready[g] = can_accept. All other req_ready bits are 0.
- ALU drive:
  - With a winner, alu_i0/alu_i1/alu_s = req_a/req_b/req_op of g.
  - With no winner, the ALU inputs hold the lowest-index requester's fields. These values are don't-care but must never be X.
- Accept: a transfer occurs on a posedge where req_valid[g] & req_ready[g]. On it:
  - rsp_data <= alu_o.
  - rsp_id <= g.
  - rsp_valid <= 1.
  - ptr <= (g+1) mod N_REQ.
- Latency: exactly 1 cycle from the accept edge to rsp_valid=1. Throughput is 1 op/cycle while rsp_ready=1.
- Drain: rsp_valid & rsp_ready with no new accept gives rsp_valid <= 0. rsp_data and rsp_id keep their last values.
- Simultaneous drain + accept: rsp_valid stays 1 and the new data/id are loaded. There is no bubble.
- Backpressure: while rsp_valid & !rsp_ready, all req_ready=0. rsp_data and rsp_id must stay stable. ptr does not change.
- ptr changes only on an accept. A requester that is stalled by backpressure keeps its turn.
- Fairness: with all N_REQ requesters continuously valid and rsp_ready=1, grants rotate 0,1,...,N_REQ-1,0,...
  - Worst-case wait for any continuously valid requester is N_REQ-1 accepts.
- Requesters may drop req_valid without being granted; the block imposes no stickiness.
- Op-select is passed through unmodified; the block does not decode ALU operations.
- No widths change: rsp_data is exactly alu_o. No sign or zero extension.

Decomposition:
- Shared package (core_pkg) holds:
  - ALU_OP_W = 4.
  - A typedef alu_op_t for logic [ALU_OP_W-1:0].
  - A typedef for the request bundle {a, b, op}, which the execute stage also uses.
- One sub-module, rr_arbiter:
  - Parameterised on N.
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot grant and grant index.
  - Purely combinational; pointer state stays in alu_arbiter.
- The response register and ptr live in the top.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with req_valid=2'b11 → req_ready=0 during reset; rsp_valid=0, rsp_data=0, rsp_id=0 after reset.
2. Single op: req0 a=32'h0000_00F0, b=32'h0000_0F0F, op=4'b1000 (OR), rsp_ready=1 → one cycle later rsp_valid=1, rsp_data=32'h0000_0FFF, rsp_id=0.
3. Round-robin: both requesters continuously valid, rsp_ready=1, for 6 cycles → rsp_id sequence 0,1,0,1,0,1 on consecutive cycles with no bubbles.
4. Backpressure: an accepted result of 32'h0000_0001 is held with rsp_ready=0 for 3 cycles while req1 is valid → req_ready=0 and rsp_data stable. On the cycle rsp_ready=1, req1 is accepted and its result appears the next cycle with rsp_id=1.
5. Reset mid-operation: assert rst in the same cycle as an accept with rsp_valid=1 → next cycle rsp_valid=0 and ptr=0. First post-reset grant goes to requester 0 when both requesters are valid.
6. N_REQ=3, only req2 valid, then all three valid → req2 granted first, then grant order 0,1,2 (ptr=0 after wrap).
